// File: rtl/weight_buf_pingpong_if.sv
// weight_buf_pingpong_if: DMA write, compute read and status signals of the ping-pong weight buffer
interface weight_buf_pingpong_if #(
  parameter int unsigned BUF_ADDR_W = 15,
  parameter int unsigned WIDTH      = 128
);
  logic                  dma_wr_en;
  logic [BUF_ADDR_W-1:0] dma_wr_addr;
  logic [WIDTH-1:0]      dma_wr_data;
  logic                  dma_wr_last;
  logic                  dma_wr_ready;
  logic                  rd_en;
  logic [BUF_ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]      rd_data;
  logic                  rd_valid;
  logic                  rd_bank_valid;
  logic                  rd_done;
  logic                  wr_sel;
  logic                  rd_sel;
  logic                  wr_err;
  logic                  rd_err;
  modport master (
    output dma_wr_en, dma_wr_addr, dma_wr_data, dma_wr_last, rd_en, rd_addr, rd_done,
    input  dma_wr_ready, rd_data, rd_valid, rd_bank_valid, wr_sel, rd_sel, wr_err, rd_err
  );
  modport slave (
    input  dma_wr_en, dma_wr_addr, dma_wr_data, dma_wr_last, rd_en, rd_addr, rd_done,
    output dma_wr_ready, rd_data, rd_valid, rd_bank_valid, wr_sel, rd_sel, wr_err, rd_err
  );
endinterface

// File: rtl/weight_buf_pingpong.sv
// weight_buf_pingpong: double-buffered weight RAM, DMA fills one bank while compute reads the other
module weight_buf_pingpong #(
  parameter int unsigned BUF_ADDR_W   = 15,
  parameter int unsigned WIDTH        = 128,
  parameter int unsigned DEPTH        = 32768,
  parameter int unsigned READ_LATENCY = 2
) (
  input logic                clka,
  input logic                rst_n,
  weight_buf_pingpong_if.slave bus
);
  localparam int unsigned AW = $clog2(2 * DEPTH);
  logic [WIDTH-1:0]                    mem [0:2*DEPTH-1];
  logic                                wr_sel;
  logic                                rd_sel;
  logic [1:0]                          full_cnt;
  logic                                wr_err;
  logic                                rd_err;
  logic                                wr_ok;
  logic                                close;
  logic                                rel;
  logic [AW-1:0]                       wr_idx;
  logic [AW-1:0]                       rd_idx;
  logic [READ_LATENCY:1]               vq;
  logic [READ_LATENCY:1][WIDTH-1:0]    dq;
  assign bus.dma_wr_ready  = full_cnt < 2'd2;
  assign bus.rd_bank_valid = |full_cnt;
  assign bus.wr_sel        = wr_sel;
  assign bus.rd_sel        = rd_sel;
  assign bus.wr_err        = wr_err;
  assign bus.rd_err        = rd_err;
  assign bus.rd_valid      = vq[READ_LATENCY];
  assign bus.rd_data       = dq[READ_LATENCY];
  assign wr_ok  = bus.dma_wr_en & bus.dma_wr_ready & (32'(bus.dma_wr_addr) < DEPTH);
  assign close  = wr_ok & bus.dma_wr_last;
  assign rel    = bus.rd_done & |full_cnt;
  // banks are packed back to back, so {bank, addr} maps to bank*DEPTH + addr
  assign wr_idx = AW'(32'(wr_sel) * DEPTH + 32'(bus.dma_wr_addr));
  assign rd_idx = AW'(32'(rd_sel) * DEPTH + 32'(bus.rd_addr));
  // storage write port; contents survive reset
  always_ff @(posedge clka)
    if (wr_ok) mem[wr_idx] <= bus.dma_wr_data;
  // bank pointers, occupancy and sticky error flags
  always_ff @(posedge clka or negedge rst_n)
    if (!rst_n) begin
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      full_cnt <= 2'd0;
      wr_err   <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      if (close) wr_sel <= ~wr_sel;
      if (rel) rd_sel <= ~rd_sel;
      full_cnt <= full_cnt + {1'b0, close} - {1'b0, rel};
      if (bus.dma_wr_en & ~wr_ok) wr_err <= 1'b1;
      if ((bus.rd_en | bus.rd_done) & ~|full_cnt) rd_err <= 1'b1;
    end
  // read pipeline: stage 1 samples the array (read-first), later stages only advance on valid data
  always_ff @(posedge clka or negedge rst_n)
    if (!rst_n) begin
      vq <= '0;
      dq <= '0;
    end else begin
      vq[1] <= bus.rd_en;
      if (bus.rd_en) dq[1] <= mem[rd_idx];
      for (int i = 2; i <= READ_LATENCY; i++) begin
        vq[i] <= vq[i-1];
        if (vq[i-1]) dq[i] <= dq[i-1];
      end
    end
endmodule
